// File: rtl/dma_pkg.sv
// Shared definitions for the DMA IO writer: FSM state encoding, default
// widths and IO device select values.
package dma_pkg;

    localparam int ADDR_W_DEF  = 9;
    localparam int DATA_W_DEF  = 32;
    localparam int CNT_W_DEF   = 8;
    localparam int TIMEOUT_DEF = 15;
    localparam int OFF_W       = 9;   // IO-side register offset width

    // dest_sel / cs encodings
    localparam logic DEV1 = 1'b0;
    localparam logic DEV2 = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        RD    = 3'd2,
        LATCH = 3'd3,
        WR    = 3'd4,
        DONE  = 3'd5
    } dma_state_e;

endpackage

// File: rtl/dma_ack_timer.sv
// Ack wait counter for the IO write phase. Counts consecutive cycles with
// run_i high and flags expiry on the TIMEOUT-th such cycle. Clears as soon
// as run_i drops, so every word gets a fresh budget.
module dma_ack_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    output logic expired_o
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // Next count: advance while waiting, restart otherwise
    always_comb begin
        cnt_d = '0;
        if (run_i) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = run_i && (cnt_q == TW'(TIMEOUT - 1));

endmodule

// File: rtl/dma_io_writer.sv
// DMA IO writer: on start, requests the bus, then copies a block of memory
// words to IO device 1 or 2, one strobe/ack write per word.
// Optional Ack timeout abort is enabled by defining DMA_ACK_TIMEOUT_EN;
// without it WR waits for Ack forever and error is tied low.
//
// IO write handshake: in WR the selected IOWrite strobe is high while
// io_data and index are held stable. The write completes on the rising
// edge where the selected Ack is sampled high; the strobe is low from the
// following cycle. The non-selected device's Ack has no effect.
module dma_io_writer
    import dma_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
`ifdef DMA_ACK_TIMEOUT_EN
    ,
    parameter int TIMEOUT = TIMEOUT_DEF
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [CNT_W-1:0]  length,
    input  logic              dest_sel,
    input  logic [OFF_W-1:0]  io_offset,
    output logic              bus_req,
    input  logic              grant,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] io_data,
    output logic [OFF_W:0]    index,
    output logic              IOWrite1,
    output logic              IOWrite2,
    input  logic              Ack1,
    input  logic              Ack2,
    output logic              busy,
    output logic              done,
    output logic              error
);

    dma_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic              sel_q, sel_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              ack_sel;

    // Only the Ack of the device being written counts
    assign ack_sel = (sel_q == DEV1) ? Ack1 : Ack2;

`ifdef DMA_ACK_TIMEOUT_EN
    logic error_q, error_d;
    logic timeout_hit;

    dma_ack_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_ack_timer (
        .clk       (clk),
        .rst       (rst),
        .run_i     (state_q == WR),
        .expired_o (timeout_hit)
    );

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    // Next-state and datapath update logic
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        off_d   = off_q;
        sel_d   = sel_q;
        data_d  = data_q;
`ifdef DMA_ACK_TIMEOUT_EN
        error_d = error_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
`ifdef DMA_ACK_TIMEOUT_EN
                    error_d = 1'b0;
`endif
                    if (length == '0) begin
                        // Empty block: complete without touching the bus
                        state_d = DONE;
                    end else begin
                        addr_d  = src_addr;
                        cnt_d   = length;
                        off_d   = io_offset;
                        sel_d   = dest_sel;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (grant) begin
                    state_d = RD;
                end
            end
            RD: begin
                state_d = LATCH;
            end
            LATCH: begin
                data_d  = mem_rdata;
                state_d = WR;
            end
            WR: begin
                if (ack_sel) begin
                    addr_d = addr_q + ADDR_W'(1);
                    off_d  = off_q + OFF_W'(1);
                    cnt_d  = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end else if (grant) begin
                        state_d = RD;
                    end else begin
                        // Bus taken back: finish this word, then re-request
                        state_d = REQ;
                    end
                end
`ifdef DMA_ACK_TIMEOUT_EN
                else if (timeout_hit) begin
                    error_d = 1'b1;
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            off_q   <= '0;
            sel_q   <= 1'b0;
            data_q  <= '0;
`ifdef DMA_ACK_TIMEOUT_EN
            error_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            off_q   <= off_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
`ifdef DMA_ACK_TIMEOUT_EN
            error_q <= error_d;
`endif
        end
    end

    // Outputs decoded from registered state only
    assign bus_req  = (state_q == REQ) || (state_q == RD) ||
                      (state_q == LATCH) || (state_q == WR);
    assign busy     = bus_req;
    assign done     = (state_q == DONE);
    assign mem_addr = addr_q;
    assign io_data  = data_q;
    assign index    = {sel_q, off_q};
    assign IOWrite1 = (state_q == WR) && (sel_q == DEV1);
    assign IOWrite2 = (state_q == WR) && (sel_q == DEV2);

endmodule

// File: tb/tb_dma_io_writer.sv
// Directed testbench for dma_io_writer: memory model with 1-cycle read,
// IO device responder with configurable Ack delay, and per-scenario tasks.
module tb_dma_io_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [8:0]  src_addr = '0;
    logic [7:0]  length = '0;
    logic        dest_sel = 1'b0;
    logic [8:0]  io_offset = '0;
    logic        grant = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        Ack1 = 1'b0;
    logic        Ack2 = 1'b0;
    logic        bus_req, IOWrite1, IOWrite2, busy, done, error;
    logic [8:0]  mem_addr;
    logic [31:0] io_data;
    logic [9:0]  index;

    int errors = 0;
    int checks = 0;

    dma_io_writer dut (
        .clk(clk), .rst(rst), .start(start), .src_addr(src_addr),
        .length(length), .dest_sel(dest_sel), .io_offset(io_offset),
        .bus_req(bus_req), .grant(grant), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .io_data(io_data), .index(index),
        .IOWrite1(IOWrite1), .IOWrite2(IOWrite2), .Ack1(Ack1), .Ack2(Ack2),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [8:0] a);
        return 32'hC0DE_0000 ^ {7'd0, a, 7'd0, a};
    endfunction

    // Memory model: synchronous read, one cycle latency
    always @(posedge clk) mem_rdata <= mem_word(mem_addr);

    // IO device responder and monitor
    int   ack_delay = 0;
    bit   withhold = 1'b0;
    bit   noise1 = 1'b0;
    int   wc = 0;
    logic ackv;
    int   hi1, hi2, both_hi, done_cnt, breq_cnt;
    logic [31:0] wr_data[$];
    logic [9:0]  wr_idx[$];
    logic        wr_dev[$];

    always @(negedge clk) begin
        if (IOWrite1 && IOWrite2) both_hi++;
        if (IOWrite1) hi1++;
        if (IOWrite2) hi2++;
        if (done) done_cnt++;
        if (bus_req) breq_cnt++;
        if (IOWrite1 || IOWrite2) begin
            ackv = (wc >= ack_delay) && !withhold;
            wc++;
        end else begin
            ackv = 1'b0;
            wc = 0;
        end
        Ack1 = (IOWrite1 && ackv) || noise1;
        Ack2 = IOWrite2 && ackv;
        if ((IOWrite1 && Ack1) || (IOWrite2 && Ack2)) begin
            wr_data.push_back(io_data);
            wr_idx.push_back(index);
            wr_dev.push_back(IOWrite2);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        hi1 = 0; hi2 = 0; both_hi = 0; done_cnt = 0; breq_cnt = 0;
        wr_data.delete(); wr_idx.delete(); wr_dev.delete();
    endtask

    task automatic do_start(input logic [8:0] a, input logic [7:0] n,
                            input logic sel, input logic [8:0] off);
        tick();
        src_addr = a; length = n; dest_sel = sel; io_offset = off;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int max, output int cyc);
        cyc = 0;
        while (!done && cyc < max) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++; if (bus_req !== 1'b0)  begin errors++; $display("FAIL reset_bus_req got %b exp 0", bus_req); end
        checks++; if (mem_addr !== 9'h0) begin errors++; $display("FAIL reset_mem_addr got %h exp 000", mem_addr); end
        checks++; if (io_data !== 32'h0) begin errors++; $display("FAIL reset_io_data got %h exp 0", io_data); end
        checks++; if (index !== 10'h0)   begin errors++; $display("FAIL reset_index got %h exp 000", index); end
        checks++; if (IOWrite1 !== 1'b0 || IOWrite2 !== 1'b0) begin errors++; $display("FAIL reset_strobes got %b%b exp 00", IOWrite1, IOWrite2); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %b%b exp 00", busy, done); end
        checks++; if (error !== 1'b0)    begin errors++; $display("FAIL reset_error got %b exp 0", error); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int cyc;
        clear_mon();
        grant = 1'b1; ack_delay = 1;
        do_start(9'h010, 8'd3, 1'b0, 9'h040);
        checks++; if (busy !== 1'b1 || bus_req !== 1'b1) begin errors++; $display("FAIL basic_busy got %b/%b exp 1/1", busy, bus_req); end
        wait_done(60, cyc);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done_timeout got %b exp 1 after %0d cycles", done, cyc); end
        checks++; if (wr_data.size() !== 3) begin errors++; $display("FAIL basic_nwrites got %0d exp 3", wr_data.size()); end
        for (int i = 0; i < 3 && i < wr_data.size(); i++) begin
            checks++; if (wr_data[i] !== mem_word(9'h010 + 9'(i))) begin errors++; $display("FAIL basic_data[%0d] got %h exp %h", i, wr_data[i], mem_word(9'h010 + 9'(i))); end
            checks++; if (wr_idx[i] !== {1'b0, 9'h040 + 9'(i)}) begin errors++; $display("FAIL basic_index[%0d] got %h exp %h", i, wr_idx[i], {1'b0, 9'h040 + 9'(i)}); end
            checks++; if (wr_dev[i] !== 1'b0) begin errors++; $display("FAIL basic_dev[%0d] got %b exp 0", i, wr_dev[i]); end
        end
        checks++; if (hi1 !== 6) begin errors++; $display("FAIL basic_iowrite1_cycles got %0d exp 6", hi1); end
        checks++; if (hi2 !== 0 || both_hi !== 0) begin errors++; $display("FAIL basic_iowrite2 got %0d/%0d exp 0/0", hi2, both_hi); end
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_after_done got done=%b busy=%b exp 0/0", done, busy); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_count got %0d exp 1", done_cnt); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL basic_error got %b exp 0", error); end
    endtask

    task automatic test_zero_len();
        clear_mon();
        do_start(9'h055, 8'd0, 1'b0, 9'h000);
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL zero_done got done=%b busy=%b exp 1/0", done, busy); end
        tick();
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_pulse got %b exp 0", done); end
        checks++; if (breq_cnt !== 0) begin errors++; $display("FAIL zero_bus_req got %0d cycles exp 0", breq_cnt); end
        checks++; if (done_cnt !== 1 || wr_data.size() !== 0 || hi1 !== 0) begin errors++; $display("FAIL zero_activity got done=%0d writes=%0d strobe=%0d exp 1/0/0", done_cnt, wr_data.size(), hi1); end
    endtask

    task automatic test_wrap();
        int cyc;
        clear_mon();
        grant = 1'b1; ack_delay = 2; noise1 = 1'b1;
        do_start(9'h1FF, 8'd2, 1'b1, 9'h1FF);
        wait_done(60, cyc);
        noise1 = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL wrap_done_timeout got %b exp 1", done); end
        checks++; if (wr_data.size() !== 2) begin errors++; $display("FAIL wrap_nwrites got %0d exp 2", wr_data.size()); end
        if (wr_data.size() == 2) begin
            checks++; if (wr_data[0] !== mem_word(9'h1FF)) begin errors++; $display("FAIL wrap_data0 got %h exp %h", wr_data[0], mem_word(9'h1FF)); end
            checks++; if (wr_data[1] !== mem_word(9'h000)) begin errors++; $display("FAIL wrap_data1 got %h exp %h", wr_data[1], mem_word(9'h000)); end
            checks++; if (wr_idx[0] !== 10'h3FF || wr_idx[1] !== 10'h200) begin errors++; $display("FAIL wrap_index got %h,%h exp 3ff,200", wr_idx[0], wr_idx[1]); end
            checks++; if (wr_dev[0] !== 1'b1 || wr_dev[1] !== 1'b1) begin errors++; $display("FAIL wrap_dev got %b%b exp 11", wr_dev[0], wr_dev[1]); end
        end
        checks++; if (hi1 !== 0) begin errors++; $display("FAIL wrap_iowrite1 got %0d exp 0", hi1); end
        checks++; if (hi2 !== 6) begin errors++; $display("FAIL wrap_iowrite2_cycles got %0d exp 6", hi2); end
    endtask

    task automatic test_latency();
        int cyc;
        clear_mon();
        grant = 1'b1; ack_delay = 0;
        do_start(9'h100, 8'd3, 1'b0, 9'h000);
        wait_done(60, cyc);
        checks++; if (done !== 1'b1 || cyc !== 10) begin errors++; $display("FAIL latency got done=%b cycles=%0d exp 1/10", done, cyc); end
        checks++; if (hi1 !== 3) begin errors++; $display("FAIL latency_strobe got %0d exp 3", hi1); end
    endtask

    task automatic test_grant_drop();
        int cyc;
        int w;
        clear_mon();
        grant = 1'b1; ack_delay = 1;
        do_start(9'h020, 8'd4, 1'b0, 9'h010);
        w = 0;
        while (!IOWrite1 && w < 20) begin tick(); w++; end
        checks++; if (IOWrite1 !== 1'b1) begin errors++; $display("FAIL gdrop_first_strobe got %b exp 1", IOWrite1); end
        grant = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        checks++; if (wr_data.size() !== 1) begin errors++; $display("FAIL gdrop_suspended_writes got %0d exp 1", wr_data.size()); end
        checks++; if (hi1 !== 2 || IOWrite1 !== 1'b0) begin errors++; $display("FAIL gdrop_strobe got cycles=%0d now=%b exp 2/0", hi1, IOWrite1); end
        checks++; if (bus_req !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL gdrop_rerequest got %b/%b exp 1/1", bus_req, busy); end
        grant = 1'b1;
        wait_done(60, cyc);
        checks++; if (done !== 1'b1 || wr_data.size() !== 4) begin errors++; $display("FAIL gdrop_complete got done=%b writes=%0d exp 1/4", done, wr_data.size()); end
        for (int i = 0; i < 4 && i < wr_data.size(); i++) begin
            checks++; if (wr_data[i] !== mem_word(9'h020 + 9'(i)) || wr_idx[i] !== {1'b0, 9'h010 + 9'(i)}) begin errors++; $display("FAIL gdrop_word[%0d] got %h/%h exp %h/%h", i, wr_data[i], wr_idx[i], mem_word(9'h020 + 9'(i)), {1'b0, 9'h010 + 9'(i)}); end
        end
    endtask

    task automatic test_reset_mid();
        int w;
        clear_mon();
        grant = 1'b1; withhold = 1'b1;
        do_start(9'h030, 8'd2, 1'b0, 9'h000);
        w = 0;
        while (!IOWrite1 && w < 20) begin tick(); w++; end
        checks++; if (IOWrite1 !== 1'b1) begin errors++; $display("FAIL rmid_strobe got %b exp 1", IOWrite1); end
        rst = 1'b1;
        tick();
        checks++; if (IOWrite1 !== 1'b0 || busy !== 1'b0 || bus_req !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rmid_abort got wr=%b busy=%b req=%b done=%b exp 0000", IOWrite1, busy, bus_req, done); end
        rst = 1'b0; withhold = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checks++; if (done_cnt !== 0 || wr_data.size() !== 0) begin errors++; $display("FAIL rmid_no_done got done=%0d writes=%0d exp 0/0", done_cnt, wr_data.size()); end
    endtask

`ifdef DMA_ACK_TIMEOUT_EN
    task automatic test_timeout();
        int cyc;
        clear_mon();
        grant = 1'b1; withhold = 1'b1; ack_delay = 0;
        do_start(9'h040, 8'd2, 1'b0, 9'h000);
        wait_done(60, cyc);
        withhold = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL tmo_done got %b exp 1", done); end
        checks++; if (hi1 !== 15) begin errors++; $display("FAIL tmo_wr_cycles got %0d exp 15", hi1); end
        checks++; if (error !== 1'b1 || bus_req !== 1'b0) begin errors++; $display("FAIL tmo_error got err=%b req=%b exp 1/0", error, bus_req); end
        tick();
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL tmo_sticky got %b exp 1", error); end
        do_start(9'h040, 8'd1, 1'b0, 9'h000);
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL tmo_clear got %b exp 0", error); end
        wait_done(60, cyc);
        checks++; if (done !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL tmo_recover got done=%b err=%b exp 1/0", done, error); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_wrap();
        test_latency();
        test_grant_drop();
        test_reset_mid();
`ifdef DMA_ACK_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
